ahb_slave_if: RTL and testbench
===============================

// Module: ahb_slave_if
// PURPOSE
//  AHB-side front end of the AHB-to-APB bridge; sits directly upstream of the APB FSM.
//  Decodes AHB address phases into valid/tempselx and pipelines address, write data and direction (Haddr1/2, Hwdata1/2, Hwritereg).
//  Returns APB read data to AHB.
//  Optionally generates a two-cycle AHB ERROR response for transfers outside the slave map.
// PARAMETERS
//  ADDR_BASE   32'h8000_0000  base address of APB slot 0
//  SLOT_SHIFT  26             log2 of slot size; slots 0..2 contiguous from ADDR_BASE (64 MB each)
// PORTS
//  clk            in   1   bridge clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  Hwrite         in   1   AHB direction of current address phase (1 = write)
//  Hreadyin       in   1   AHB HREADY seen by the bridge (top level feeds back Hreadyout & err_hreadyout)
//  Htrans         in   2   AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  Haddr          in   32  AHB address
//  Hwdata         in   32  AHB write data (data phase, one cycle after address)
//  Prdata         in   32  APB read data from selected slave
//  valid          out  1   accepted in-map transfer this cycle (comb) -> APB FSM
//  tempselx       out  3   one-hot slave select decoded from Haddr (comb)
//  Haddr1         out  32  Haddr delayed 1 accepted cycle
//  Haddr2         out  32  Haddr1 delayed 1 accepted cycle
//  Hwdata1        out  32  Hwdata delayed 1 accepted cycle
//  Hwdata2        out  32  Hwdata1 delayed 1 accepted cycle
//  Hwritereg      out  1   Hwrite delayed 1 accepted cycle
//  Hrdata         out  32  AHB read data, equals Prdata (comb)
//  Hresp          out  2   AHB response: 00 OKAY, 01 ERROR
//  err_hreadyout  out  1   HREADY contribution of error logic (0 only in first ERROR cycle)
// BEHAVIOUR
//  - active = Htrans[1] (NONSEQ/SEQ); inmap = Haddr in [ADDR_BASE, ADDR_BASE + 3<<SLOT_SHIFT).
//  - tempselx: slot = (Haddr-ADDR_BASE)>>SLOT_SHIFT; 0->001, 1->010, 2->100; out of map -> 000.
//  - valid = Hreadyin & active & inmap & (err_state != E_ERR1). IDLE/BUSY never raise valid.
//  - Pipeline regs update only when Hreadyin=1; hold otherwise:
//    Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite.
//  - Latency: valid and tempselx same cycle as address phase; Haddr1/Hwritereg next cycle; Haddr2/Hwdata2 two accepted cycles later.
//  - Hrdata = Prdata, no register (APB FSM sequences read completion via Hreadyout).
//  - Reset (async, any cycle incl. mid-transfer): Haddr1/2, Hwdata1/2 = 0; Hwritereg = 0; err FSM -> E_OKAY.
//    Hresp = 00, err_hreadyout = 1; valid/tempselx follow inputs (comb); pending ERROR abandoned.
//  - 32-bit unsigned arithmetic; Haddr < ADDR_BASE is out of map (no wrap-around into slots).
// CONFIGURATION
//  AHB_ERR_RESP_EN defined:
//    - Error FSM has three states, E_OKAY, E_ERR1 and E_ERR2.
//    - E_OKAY -> E_ERR1 when Hreadyin & active & !inmap; otherwise stay in E_OKAY.
//    - E_ERR1: Hresp=01, err_hreadyout=0, valid forced 0; always -> E_ERR2.
//    - E_ERR2: Hresp=01, err_hreadyout=1; the address phase sampled here is decoded normally.
//      Out of map -> E_ERR1; otherwise -> E_OKAY.
//    - E_OKAY: Hresp=00, err_hreadyout=1.
//  AHB_ERR_RESP_EN undefined:
//    - No error FSM; Hresp tied 00, err_hreadyout tied 1.
//    - Out-of-map transfers get OKAY with zero wait and valid=0 (write dropped, read returns Prdata as-is).
// TESTING
//  T1 reset: rst=1 mid-write -> all reg outputs 0, Hresp=00, err_hreadyout=1 within same cycle, before any clk edge.
//  T2 decode: Htrans=10, Hreadyin=1, Haddr=32'h8400_0010 -> valid=1, tempselx=010. Haddr=32'h8BFF_FFFC -> tempselx=100.
//  T3 pipeline: NONSEQ write A=32'h8000_0000, then A=32'h8000_0004 with Hwdata=32'hDEAD_BEEF.
//     -> next cycle Haddr1=32'h8000_0004, Haddr2=32'h8000_0000, Hwdata1=32'hDEAD_BEEF, Hwritereg=1.
//  T4 stall: Hreadyin=0 for 3 cycles with Haddr changing -> Haddr1/Haddr2/Hwdata1/Hwdata2/Hwritereg unchanged; valid=0.
//  T5 IDLE/BUSY: Htrans=00 then 01 at Haddr=32'h8000_0000 -> valid=0, Hresp=00.
//  T6 error (AHB_ERR_RESP_EN): NONSEQ to 32'h9000_0000 -> valid=0.
//     Next cycle Hresp=01 & err_hreadyout=0, then Hresp=01 & err_hreadyout=1, then Hresp=00.
//     Without the macro: Hresp stays 00, err_hreadyout stays 1.

Source files
------------

// File: rtl/ahb_slave_if_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if_if
// Description : Bus bundle between the AHB side of the AHB-to-APB bridge and
//               its AHB slave front end (address/data pipeline, decode, resp).
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_slave_if_if;
   // AHB / APB inputs to the front end
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   // Front-end outputs
   logic        valid;
   logic [2:0]  tempselx;
   logic [31:0] Haddr1;
   logic [31:0] Haddr2;
   logic [31:0] Hwdata1;
   logic [31:0] Hwdata2;
   logic        Hwritereg;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        err_hreadyout;

   modport master (
      output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
      input  valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
             Hwritereg, Hrdata, Hresp, err_hreadyout
   );

   modport slave (
      input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
      output valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
             Hwritereg, Hrdata, Hresp, err_hreadyout
   );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if
// Description : AHB-side front end of the AHB-to-APB bridge. Decodes address
//               phases into valid/tempselx, pipelines address, write data and
//               direction, and returns APB read data to AHB.
//               Optional macro AHB_ERR_RESP_EN adds a two-cycle ERROR
//               response for transfers outside the three-slot slave map.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_if #(
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter int          SLOT_SHIFT = 26
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ahb_slave_if_if.slave   bus
);

   // Map spans three slots; 33 bits so the bound can never overflow.
   localparam logic [32:0] c_MAP_SIZE = 33'(3) << SLOT_SHIFT;

   logic        w_active;
   logic        w_req;
   logic        w_inmap;
   logic [31:0] w_offset;
   logic [1:0]  w_slot;
   logic        w_in_err1;
   logic        w_unused;

   logic [31:0] haddr1_q,  haddr1_d;
   logic [31:0] haddr2_q,  haddr2_d;
   logic [31:0] hwdata1_q, hwdata1_d;
   logic [31:0] hwdata2_q, hwdata2_d;
   logic        hwritereg_q, hwritereg_d;

   // Htrans[0] only distinguishes BUSY/SEQ, which this block treats alike.
   assign w_unused = &{1'b0, bus.Htrans[0]};

   // Address decode: below-base addresses are rejected before subtraction.
   always_comb begin
      w_active = bus.Htrans[1];
      w_req    = bus.Hreadyin & w_active;
      w_offset = bus.Haddr - ADDR_BASE;
      w_inmap  = (bus.Haddr >= ADDR_BASE) && ({1'b0, w_offset} < c_MAP_SIZE);
      w_slot   = 2'(w_offset >> SLOT_SHIFT);
      bus.tempselx = 3'b000;
      if (w_inmap) begin
         case (w_slot)
            2'd0:    bus.tempselx = 3'b001;
            2'd1:    bus.tempselx = 3'b010;
            2'd2:    bus.tempselx = 3'b100;
            default: bus.tempselx = 3'b000;
         endcase
      end
      bus.valid = w_req & w_inmap & ~w_in_err1;
   end

   // Pipeline next-state: advance only on accepted (Hreadyin) cycles.
   always_comb begin
      haddr1_d    = haddr1_q;
      haddr2_d    = haddr2_q;
      hwdata1_d   = hwdata1_q;
      hwdata2_d   = hwdata2_q;
      hwritereg_d = hwritereg_q;
      if (bus.Hreadyin) begin
         haddr1_d    = bus.Haddr;
         haddr2_d    = haddr1_q;
         hwdata1_d   = bus.Hwdata;
         hwdata2_d   = hwdata1_q;
         hwritereg_d = bus.Hwrite;
      end
   end

   // Pipeline registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         haddr1_q    <= 32'h0;
         haddr2_q    <= 32'h0;
         hwdata1_q   <= 32'h0;
         hwdata2_q   <= 32'h0;
         hwritereg_q <= 1'b0;
      end else begin
         haddr1_q    <= haddr1_d;
         haddr2_q    <= haddr2_d;
         hwdata1_q   <= hwdata1_d;
         hwdata2_q   <= hwdata2_d;
         hwritereg_q <= hwritereg_d;
      end
   end

   assign bus.Haddr1    = haddr1_q;
   assign bus.Haddr2    = haddr2_q;
   assign bus.Hwdata1   = hwdata1_q;
   assign bus.Hwdata2   = hwdata2_q;
   assign bus.Hwritereg = hwritereg_q;

   // Read data passes straight through; the APB FSM times completion.
   assign bus.Hrdata = bus.Prdata;

`ifdef AHB_ERR_RESP_EN
   typedef enum logic [1:0] {
      E_OKAY = 2'd0,
      E_ERR1 = 2'd1,
      E_ERR2 = 2'd2
   } err_state_t;

   err_state_t err_state_q, err_state_d;
   logic [1:0] hresp_q, hresp_d;
   logic       err_hready_q, err_hready_d;

   // Error FSM next state; outputs are derived from the next state so they
   // can be registered alongside it.
   always_comb begin
      err_state_d = err_state_q;
      case (err_state_q)
         E_OKAY:  if (w_req && !w_inmap) err_state_d = E_ERR1;
         E_ERR1:  err_state_d = E_ERR2;
         E_ERR2:  err_state_d = (w_req && !w_inmap) ? E_ERR1 : E_OKAY;
         default: err_state_d = E_OKAY;
      endcase
      hresp_d      = (err_state_d == E_OKAY) ? 2'b00 : 2'b01;
      err_hready_d = (err_state_d != E_ERR1);
   end

   // Error FSM state and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_state_q  <= E_OKAY;
         hresp_q      <= 2'b00;
         err_hready_q <= 1'b1;
      end else begin
         err_state_q  <= err_state_d;
         hresp_q      <= hresp_d;
         err_hready_q <= err_hready_d;
      end
   end

   assign w_in_err1         = (err_state_q == E_ERR1);
   assign bus.Hresp         = hresp_q;
   assign bus.err_hreadyout = err_hready_q;
`else
   // Out-of-map transfers simply complete OKAY with valid held low.
   assign w_in_err1         = 1'b0;
   assign bus.Hresp         = 2'b00;
   assign bus.err_hreadyout = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_if
// Description : Self-checking bench for ahb_slave_if: decode vector table,
//               scoreboarded pipeline sequences, error response and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_if;

`ifdef AHB_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ahb_slave_if_if bus ();

   ahb_slave_if dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [1:0]  htrans;
      logic        ready;
      logic [31:0] addr;
      logic        exp_valid;
      logic [2:0]  exp_sel;
   } vec_t;

   typedef struct {
      logic [31:0] a1, a2, w1, w2;
      logic        wr;
   } pipe_t;

   vec_t  vt[11];
   pipe_t sb[$];
   pipe_t m;

   function automatic bit tb_inmap(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] ht, input logic rdy, input logic [31:0] a,
                        input logic [31:0] wd, input logic wr);
      bus.Htrans   = ht;
      bus.Hreadyin = rdy;
      bus.Haddr    = a;
      bus.Hwdata   = wd;
      bus.Hwrite   = wr;
   endtask

   // One bus cycle: expected pipeline state pushed at drive, popped after edge.
   task automatic pipe_cycle(input logic [1:0] ht, input logic rdy, input logic [31:0] a,
                             input logic [31:0] wd, input logic wr);
      pipe_t e;
      @(negedge clk);
      drive(ht, rdy, a, wd, wr);
      if (rdy) begin
         m.a2 = m.a1;
         m.a1 = a;
         m.w2 = m.w1;
         m.w1 = wd;
         m.wr = wr;
      end
      sb.push_back(m);
      #1;
      check("valid", {31'b0, bus.valid}, {31'b0, rdy & ht[1] & tb_inmap(a)});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sb.pop_front();
         check("Haddr1", bus.Haddr1, e.a1);
         check("Haddr2", bus.Haddr2, e.a2);
         check("Hwdata1", bus.Hwdata1, e.w1);
         check("Hwdata2", bus.Hwdata2, e.w2);
         check("Hwritereg", {31'b0, bus.Hwritereg}, {31'b0, e.wr});
      end
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, " Haddr1"}, bus.Haddr1, 32'h0);
      check({tag, " Haddr2"}, bus.Haddr2, 32'h0);
      check({tag, " Hwdata1"}, bus.Hwdata1, 32'h0);
      check({tag, " Hwdata2"}, bus.Hwdata2, 32'h0);
      check({tag, " Hwritereg"}, {31'b0, bus.Hwritereg}, 32'h0);
      check({tag, " Hresp"}, {30'b0, bus.Hresp}, 32'h0);
      check({tag, " err_hreadyout"}, {31'b0, bus.err_hreadyout}, 32'h1);
   endtask

   task automatic check_resp(input string tag, input logic [1:0] r, input logic h);
      check({tag, " Hresp"}, {30'b0, bus.Hresp}, {30'b0, r});
      check({tag, " err_hreadyout"}, {31'b0, bus.err_hreadyout}, {31'b0, h});
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;

      //          htrans  rdy  addr           valid sel
      vt[0]  = '{2'b10, 1'b1, 32'h8400_0010, 1'b1, 3'b010};
      vt[1]  = '{2'b10, 1'b1, 32'h8BFF_FFFC, 1'b1, 3'b100};
      vt[2]  = '{2'b10, 1'b1, 32'h8000_0000, 1'b1, 3'b001};
      vt[3]  = '{2'b11, 1'b1, 32'h83FF_FFFF, 1'b1, 3'b001};
      vt[4]  = '{2'b10, 1'b1, 32'h8C00_0000, 1'b0, 3'b000};
      vt[5]  = '{2'b10, 1'b1, 32'h7FFF_FFFC, 1'b0, 3'b000};
      vt[6]  = '{2'b00, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
      vt[7]  = '{2'b01, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
      vt[8]  = '{2'b10, 1'b0, 32'h8800_0000, 1'b0, 3'b100};
      vt[9]  = '{2'b10, 1'b1, 32'h9000_0000, 1'b0, 3'b000};
      vt[10] = '{2'b11, 1'b1, 32'h0000_0000, 1'b0, 3'b000};

      drive(2'b00, 1'b1, 32'h0, 32'h0, 1'b0);
      bus.Prdata = 32'h0;
      #1 rst = 1'b1;
      #1 check_regs_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Decode table: held only between negedge and the next posedge, then
      // returned to IDLE so the error FSM never advances here.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(vt[i].htrans, vt[i].ready, vt[i].addr, 32'h0, 1'b0);
         rd = $urandom;
         bus.Prdata = rd;
         #1;
         check($sformatf("vec%0d valid", i), {31'b0, bus.valid}, {31'b0, vt[i].exp_valid});
         check($sformatf("vec%0d tempselx", i), {29'b0, bus.tempselx}, {29'b0, vt[i].exp_sel});
         check($sformatf("vec%0d Hrdata", i), bus.Hrdata, rd);
         check($sformatf("vec%0d Hresp", i), {30'b0, bus.Hresp}, 32'h0);
         bus.Htrans = 2'b00;
      end

      // Fresh reset so the pipeline model starts from zero.
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      m = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0};

      // Two back-to-back NONSEQ writes.
      pipe_cycle(2'b10, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
      pipe_cycle(2'b10, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1);
      check("T3 Haddr1", bus.Haddr1, 32'h8000_0004);
      check("T3 Haddr2", bus.Haddr2, 32'h8000_0000);
      check("T3 Hwdata1", bus.Hwdata1, 32'hDEAD_BEEF);
      check("T3 Hwritereg", {31'b0, bus.Hwritereg}, 32'h1);

      // Stall with address/data moving underneath.
      pipe_cycle(2'b10, 1'b0, 32'h8000_0100, 32'h1111_1111, 1'b0);
      pipe_cycle(2'b11, 1'b0, 32'h8400_0200, 32'h2222_2222, 1'b0);
      pipe_cycle(2'b10, 1'b0, 32'h8800_0300, 32'h3333_3333, 1'b0);
      check("T4 Haddr1 held", bus.Haddr1, 32'h8000_0004);

      // Resume, then a run of random in-map traffic.
      pipe_cycle(2'b11, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 1'b0);
      for (int i = 0; i < 10; i++) begin
         a = 32'h8000_0000 + ($urandom_range(0, 32'h0BFF_FFFF) & 32'hFFFF_FFFC);
         pipe_cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                    1'($urandom_range(0, 1)));
      end

      // Error response, including a back-to-back out-of-map transfer.
      @(negedge clk);
      drive(2'b10, 1'b1, 32'h9000_0000, 32'h0, 1'b1);
      #1;
      check("T6 valid oom", {31'b0, bus.valid}, 32'h0);
      check_resp("T6 pre", 2'b00, 1'b1);
      @(negedge clk);
      check_resp("T6 err1", ERR_EN ? 2'b01 : 2'b00, ERR_EN ? 1'b0 : 1'b1);
      drive(2'b10, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
      #1;
      check("T6 valid in err1", {31'b0, bus.valid}, ERR_EN ? 32'h0 : 32'h1);
      @(negedge clk);
      check_resp("T6 err2", ERR_EN ? 2'b01 : 2'b00, 1'b1);
      drive(2'b11, 1'b1, 32'hF000_0000, 32'h0, 1'b0);
      @(negedge clk);
      check_resp("T6 re-err1", ERR_EN ? 2'b01 : 2'b00, ERR_EN ? 1'b0 : 1'b1);
      drive(2'b00, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
      @(negedge clk);
      check_resp("T6 re-err2", ERR_EN ? 2'b01 : 2'b00, 1'b1);
      @(negedge clk);
      check_resp("T6 okay", 2'b00, 1'b1);

      // Asynchronous reset mid-write, with an ERROR pending where enabled.
      drive(2'b10, 1'b1, 32'h8000_0008, 32'h1234_5678, 1'b1);
      @(negedge clk);
      drive(2'b10, 1'b1, 32'h9000_0000, 32'h8765_4321, 1'b1);
      @(posedge clk);
      #2;
      check("T1 pre Haddr1", bus.Haddr1, 32'h9000_0000);
      drive(2'b10, 1'b1, 32'h8400_0000, 32'hAAAA_5555, 1'b1);
      rst = 1'b1;
      #1;
      check_regs_zero("T1");
      check("T1 valid comb", {31'b0, bus.valid}, 32'h1);
      check("T1 tempselx comb", {29'b0, bus.tempselx}, 32'h2);
      #2 rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
